// File: rtl/lbp_host.sv
// LBP host: frame loader, gray-pixel read responder, result memory and readout streamer.
// Optional result checksum enabled by defining LBP_HOST_CHECKSUM_EN.
module lbp_host #(
    parameter int AW   = 14,
    parameter int NPIX = 16384
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          load_valid,
    input  logic [7:0]    load_data,
    output logic          load_ready,
    input  logic          gray_req,
    input  logic [AW-1:0] gray_addr,
    output logic          gray_ready,
    output logic [7:0]    gray_data,
    input  logic          lbp_valid,
    input  logic [AW-1:0] lbp_addr,
    input  logic [7:0]    lbp_data,
    input  logic          finish,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [AW-1:0] dout_addr,
    output logic [7:0]    dout_data,
    output logic          done,
    output logic [15:0]   checksum
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SERVE, S_DUMP, S_DONE} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

    logic [7:0] gray_mem [NPIX];
    logic [7:0] res_mem  [NPIX];

    state_t        state_q, state_d;
    logic [AW-1:0] load_cnt_q, load_cnt_d;
    logic [AW-1:0] dout_addr_q, dout_addr_d;
    logic          load_ready_q, load_ready_d;
    logic          gray_ready_q, gray_ready_d;
    logic          dout_valid_q, dout_valid_d;
    logic          done_q, done_d;
    logic [7:0]    gray_data_q, gray_data_d;
    logic [7:0]    dout_data_q, dout_data_d;

    logic          load_we_s, lbp_we_s, gray_rd_s, dump_adv_s;
    logic [AW-1:0] dump_next_s;

    // Next-state and next-output computation for the frame sequencer.
    always_comb begin
        load_we_s    = (state_q == S_LOAD) && load_valid;
        gray_rd_s    = (state_q == S_SERVE) && gray_req;
        lbp_we_s     = (state_q == S_SERVE) && lbp_valid;
        dump_adv_s   = (state_q == S_DUMP) && dout_valid_q && dout_ready;
        dump_next_s  = dout_addr_q + {{(AW-1){1'b0}}, 1'b1};

        state_d      = state_q;
        load_cnt_d   = load_cnt_q;
        dout_addr_d  = dout_addr_q;
        load_ready_d = load_ready_q;
        gray_ready_d = gray_ready_q;
        dout_valid_d = dout_valid_q;
        done_d       = done_q;
        dout_data_d  = dout_data_q;

        if (gray_rd_s) begin
            gray_data_d = gray_mem[gray_addr];
        end else begin
            gray_data_d = gray_data_q;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_LOAD;
                    load_cnt_d   = '0;
                    load_ready_d = 1'b1;
                    done_d       = 1'b0;
                    dout_valid_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_LOAD: begin
                if (load_we_s && (load_cnt_q == LAST_ADDR)) begin
                    state_d      = S_SERVE;
                    load_cnt_d   = '0;
                    load_ready_d = 1'b0;
                    gray_ready_d = 1'b1;
                end else if (load_we_s) begin
                    load_cnt_d = load_cnt_q + {{(AW-1){1'b0}}, 1'b1};
                end else begin
                    load_cnt_d = load_cnt_q;
                end
            end
            S_SERVE: begin
                if (finish) begin
                    state_d      = S_DUMP;
                    gray_ready_d = 1'b0;
                    dout_valid_d = 1'b1;
                    dout_addr_d  = '0;
                    // The finishing cycle may still write location 0, which the
                    // memory read below would miss.
                    if (lbp_we_s && (lbp_addr == '0)) begin
                        dout_data_d = lbp_data;
                    end else begin
                        dout_data_d = res_mem[0];
                    end
                end else begin
                    state_d = S_SERVE;
                end
            end
            S_DUMP: begin
                if (dump_adv_s && (dout_addr_q == LAST_ADDR)) begin
                    state_d      = S_DONE;
                    dout_valid_d = 1'b0;
                    done_d       = 1'b1;
                end else if (dump_adv_s) begin
                    dout_addr_d = dump_next_s;
                    dout_data_d = res_mem[dump_next_s];
                end else begin
                    dout_addr_d = dout_addr_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            load_cnt_q   <= '0;
            dout_addr_q  <= '0;
            load_ready_q <= 1'b0;
            gray_ready_q <= 1'b0;
            dout_valid_q <= 1'b0;
            done_q       <= 1'b0;
            gray_data_q  <= 8'h00;
            dout_data_q  <= 8'h00;
        end else begin
            state_q      <= state_d;
            load_cnt_q   <= load_cnt_d;
            dout_addr_q  <= dout_addr_d;
            load_ready_q <= load_ready_d;
            gray_ready_q <= gray_ready_d;
            dout_valid_q <= dout_valid_d;
            done_q       <= done_d;
            gray_data_q  <= gray_data_d;
            dout_data_q  <= dout_data_d;
        end
    end

    // Memory writes; loading a pixel also clears the matching result location.
    always_ff @(posedge clk) begin
        if (!reset && load_we_s) begin
            gray_mem[load_cnt_q] <= load_data;
            res_mem[load_cnt_q]  <= 8'h00;
        end else if (!reset && lbp_we_s) begin
            res_mem[lbp_addr] <= lbp_data;
        end
    end

`ifdef LBP_HOST_CHECKSUM_EN
    logic [15:0] checksum_q, checksum_d;

    // Running sum of accepted result bytes for the current frame.
    always_comb begin
        if ((state_q == S_IDLE || state_q == S_DONE) && start) begin
            checksum_d = 16'h0000;
        end else if (lbp_we_s) begin
            checksum_d = checksum_q + {8'h00, lbp_data};
        end else begin
            checksum_d = checksum_q;
        end
    end

    // Checksum register.
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_q <= 16'h0000;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 16'h0000;
`endif

    assign load_ready = load_ready_q;
    assign gray_ready = gray_ready_q;
    assign gray_data  = gray_data_q;
    assign dout_valid = dout_valid_q;
    assign dout_addr  = dout_addr_q;
    assign dout_data  = dout_data_q;
    assign done       = done_q;

endmodule

// File: tb/tb_lbp_host.sv
// Self-checking bench for lbp_host: table-driven reads, randomized serve traffic against
// a frame-level model, full-frame readout with a toggling consumer.
module tb_lbp_host;
    localparam int AW   = 14;
    localparam int NPIX = 16384;

    logic          clk = 1'b0;
    logic          reset, start, load_valid, gray_req, lbp_valid, finish, dout_ready;
    logic [7:0]    load_data, lbp_data;
    logic [AW-1:0] gray_addr, lbp_addr;
    logic          load_ready, gray_ready, dout_valid, done;
    logic [7:0]    gray_data, dout_data;
    logic [AW-1:0] dout_addr;
    logic [15:0]   checksum;

    lbp_host #(.AW(AW), .NPIX(NPIX)) dut (
        .clk(clk), .reset(reset), .start(start),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .gray_req(gray_req), .gray_addr(gray_addr), .gray_ready(gray_ready), .gray_data(gray_data),
        .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data), .finish(finish),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_addr(dout_addr),
        .dout_data(dout_data), .done(done), .checksum(checksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    exp;
    } rd_vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  gm [NPIX];
    logic [7:0]  rm [NPIX];
    logic [15:0] csum;
    logic [7:0]  last_gray;
    rd_vec_t     vecs [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    function automatic logic [15:0] exp_csum();
`ifdef LBP_HOST_CHECKSUM_EN
        return csum;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
        lbp_valid = 1'b1;
        lbp_addr  = a;
        lbp_data  = d;
        step();
        lbp_valid = 1'b0;
        rm[a]     = d;
        csum      = csum + 16'(d);
    endtask

    initial begin
        int cnt;
        int cyc;
        int exp_a;
        logic          rq;
        logic [AW-1:0] ra;
        logic [7:0]    rd;

        reset = 1'b1; start = 1'b0; load_valid = 1'b0; load_data = 8'h00;
        gray_req = 1'b0; gray_addr = '0; lbp_valid = 1'b0; lbp_addr = '0;
        lbp_data = 8'h00; finish = 1'b0; dout_ready = 1'b0;
        csum = 16'h0000;
        last_gray = 8'h00;
        for (int i = 0; i < NPIX; i++) begin
            gm[i] = 8'(i);
            rm[i] = 8'h00;
        end
        vecs[0] = '{14'h0081, 8'h81};
        vecs[1] = '{14'd5,    8'h05};
        vecs[2] = '{14'd6,    8'h06};
        vecs[3] = '{14'd7,    8'h07};
        vecs[4] = '{14'd0,    8'h00};
        vecs[5] = '{14'h3FFF, 8'hFF};

        repeat (2) step();
        reset = 1'b0;
        chk("rst_load_ready", 32'(load_ready), 32'd0);
        chk("rst_gray_ready", 32'(gray_ready), 32'd0);
        chk("rst_gray_data",  32'(gray_data),  32'd0);
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_dout_addr",  32'(dout_addr),  32'd0);
        chk("rst_dout_data",  32'(dout_data),  32'd0);
        chk("rst_done",       32'(done),       32'd0);
        chk("rst_checksum",   32'(checksum),   32'd0);

        // Partial load interrupted by reset.
        pulse_start();
        chk("load_ready_after_start", 32'(load_ready), 32'd1);
        for (int i = 0; i < 100; i++) begin
            load_valid = 1'b1;
            load_data  = 8'hFF ^ 8'(i);
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        load_valid = 1'b0;
        chk("midload_rst_load_ready", 32'(load_ready), 32'd0);
        chk("midload_rst_gray_ready", 32'(gray_ready), 32'd0);
        step();
        chk("idle_holds_load_ready", 32'(load_ready), 32'd0);

        // Full ramp load, with ignored serve-side traffic mixed in.
        pulse_start();
        cnt = 0;
        cyc = 0;
        while (cnt < NPIX && cyc < 30000) begin
            load_valid = ($urandom_range(0, 7) != 0);
            load_data  = 8'(cnt);
            gray_req   = 1'b1;
            gray_addr  = AW'($urandom);
            finish     = 1'b1;
            lbp_valid  = 1'b1;
            lbp_addr   = 14'd13;
            lbp_data   = 8'hEE;
            if (load_valid && load_ready) cnt++;
            step();
            cyc++;
        end
        load_valid = 1'b0; gray_req = 1'b0; finish = 1'b0; lbp_valid = 1'b0;
        chk("load_complete_in_budget", 32'(cnt), 32'(NPIX));
        chk("serve_load_ready", 32'(load_ready), 32'd0);
        chk("serve_gray_ready", 32'(gray_ready), 32'd1);
        chk("gray_data_untouched_in_load", 32'(gray_data), 32'd0);

        // Overwrite of one location and the checksum it produces.
        wr(14'd3, 8'h11);
        wr(14'd3, 8'h22);
`ifdef LBP_HOST_CHECKSUM_EN
        chk("checksum_after_3", 32'(checksum), 32'h0033);
`else
        chk("checksum_after_3", 32'(checksum), 32'h0000);
`endif

        // Simultaneous read and write of the same address.
        gray_req = 1'b1; gray_addr = 14'd10;
        wr(14'd10, 8'hA5);
        gray_req = 1'b0;
        last_gray = gm[10];
        chk("same_cycle_gray_data", 32'(gray_data), 32'(gm[10]));

        // Back-to-back table reads.
        for (int i = 0; i < 6; i++) begin
            gray_req  = 1'b1;
            gray_addr = vecs[i].addr;
            step();
            last_gray = vecs[i].exp;
            chk($sformatf("tbl_read_%0d", i), 32'(gray_data), 32'(vecs[i].exp));
        end
        gray_req = 1'b0;
        repeat (3) step();
        chk("gray_data_holds", 32'(gray_data), 32'(last_gray));

        pulse_start();
        chk("start_ignored_in_serve", 32'(gray_ready), 32'd1);

        // Randomized mixed reads and writes.
        for (int i = 0; i < 300; i++) begin
            rq = 1'($urandom);
            ra = AW'($urandom);
            gray_req  = rq;
            gray_addr = ra;
            lbp_valid = 1'($urandom);
            lbp_addr  = AW'($urandom);
            lbp_data  = 8'($urandom);
            if (lbp_valid) begin
                rm[lbp_addr] = lbp_data;
                csum = csum + 16'(lbp_data);
            end
            step();
            if (rq) last_gray = gm[ra];
            chk("rand_gray_data", 32'(gray_data), 32'(last_gray));
        end
        gray_req = 1'b0; lbp_valid = 1'b0;

        // Result sweep leaving a few locations untouched.
        for (int a = 0; a < NPIX; a++) begin
            if (a != 3 && a != 10 && (a % 997) != 13) begin
                lbp_valid = 1'b1;
                lbp_addr  = AW'(a);
                lbp_data  = 8'(a);
                rm[a]     = 8'(a);
                csum      = csum + 16'(8'(a));
            end else begin
                lbp_valid = 1'b0;
                rm[a]     = (a % 997 == 13) ? 8'h00 : rm[a];
            end
            step();
        end

        // Finish with a last write to address 0 and a last read.
        finish = 1'b1; gray_req = 1'b1; gray_addr = 14'd20;
        wr(14'd0, 8'h77);
        finish = 1'b0; gray_req = 1'b0;
        last_gray = gm[20];
        chk("finish_cycle_read", 32'(gray_data), 32'(last_gray));
        chk("dump_gray_ready", 32'(gray_ready), 32'd0);
        chk("dump_entry_valid", 32'(dout_valid), 32'd1);

        // Readout with a toggling consumer and ignored traffic.
        exp_a = 0;
        cyc = 0;
        while (exp_a < NPIX && cyc < 40000) begin
            dout_ready = ~cyc[0];
            start      = (cyc == 100);
            gray_req   = 1'b1;
            gray_addr  = AW'($urandom);
            lbp_valid  = 1'b1;
            lbp_addr   = AW'($urandom);
            lbp_data   = 8'($urandom);
            chk("dump_valid", 32'(dout_valid), 32'd1);
            chk("dump_addr",  32'(dout_addr),  32'(exp_a));
            chk("dump_data",  32'(dout_data),  32'(rm[exp_a]));
            if (dout_ready) exp_a++;
            step();
            cyc++;
        end
        start = 1'b0; gray_req = 1'b0; lbp_valid = 1'b0; dout_ready = 1'b0;
        chk("dump_handshakes_in_budget", 32'(exp_a), 32'(NPIX));
        chk("done_set",        32'(done),       32'd1);
        chk("done_valid_low",  32'(dout_valid), 32'd0);
        chk("dump_gray_unchanged", 32'(gray_data), 32'(last_gray));
        chk("final_checksum",  32'(checksum),   32'(exp_csum()));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lbp_host.md
LBP_HOST -- requirements
Module: lbp_host

Interface
REQ-001 SHALL have parameter AW, default 14, meaning pixel address width.
REQ-002 SHALL have parameter NPIX, default 16384, meaning pixels per frame (128 x 128).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  in  1  one-cycle pulse that begins a frame load from IDLE or DONE.
REQ-006 SHALL have ports load_valid in 1, load_data in 8, load_ready out 1: raster-order gray pixel input stream.
REQ-007 SHALL have ports gray_req in 1, gray_addr in AW, gray_ready out 1, gray_data out 8: read responder toward the LBP engine.
REQ-008 SHALL have ports lbp_valid in 1, lbp_addr in AW, lbp_data in 8, finish in 1: result writer from the LBP engine.
REQ-009 SHALL have ports dout_valid out 1, dout_ready in 1, dout_addr out AW, dout_data out 8, done out 1: result readout stream.
REQ-010 SHALL have port checksum  out  16  sum of accepted result bytes (see Configuration).

Function
REQ-011 SHALL contain an NPIX x 8 gray memory and an NPIX x 8 result memory.
REQ-012 SHALL implement FSM states IDLE, LOAD, SERVE, DUMP, DONE.
REQ-013 IDLE/DONE -> LOAD on start=1; start ignored in LOAD, SERVE, DUMP.
REQ-014 LOAD: load_ready=1; each cycle with load_valid=1 writes load_data to gray memory at load counter, counter +1.
REQ-015 LOAD -> SERVE in the cycle after the write at counter NPIX-1; counter returns to 0.
REQ-016 SERVE: gray_ready=1; gray_ready=0 in all other states.
REQ-017 SERVE: gray_req=1 at edge N registers gray memory[gray_addr] onto gray_data, valid from edge N to edge N+1 (one-cycle latency); back-to-back requests each return in order.
REQ-018 gray_data SHALL hold its last value when gray_req=0, and SHALL read 0x00 from reset until the first served request.
REQ-019 SERVE: lbp_valid=1 writes lbp_data to result memory[lbp_addr]; same-address rewrite keeps the last value.
REQ-020 gray_req and lbp_valid in the same cycle SHALL both be serviced in that cycle.
REQ-021 SERVE -> DUMP on finish=1; an lbp_valid in that same cycle SHALL still be written.
REQ-022 gray_req, lbp_valid, finish outside SERVE SHALL be ignored.
REQ-023 DUMP: present result memory at dump counter 0..NPIX-1 with dout_valid=1; advance only when dout_valid and dout_ready both 1; dout_addr/dout_data stable while stalled.
REQ-024 DUMP -> DONE after the handshake at address NPIX-1; DONE: done=1, dout_valid=0.
REQ-025 Result locations not written during SERVE SHALL dump as 0x00 (result memory cleared to 0 at entry to LOAD, one location per load write, all locations covered by frame end).

Reset
REQ-026 reset=1 at a rising edge SHALL force IDLE from any state, including mid-LOAD and mid-DUMP.
REQ-027 Reset values: load_ready=0, gray_ready=0, gray_data=0x00, dout_valid=0, dout_addr=0, dout_data=0x00, done=0, checksum=0, all counters 0.
REQ-028 Reset SHALL NOT clear memory arrays.

Configuration
REQ-029 Macro LBP_HOST_CHECKSUM_EN defined: checksum cleared on LOAD entry, adds lbp_data (mod 2^16) per accepted SERVE write, including overwrites; holds in DUMP/DONE.
REQ-030 Macro LBP_HOST_CHECKSUM_EN undefined: checksum port present, constant 0x0000, no adder logic.

Verification
REQ-031 Reset during LOAD after 100 pixels -> next cycle IDLE, load_ready=0; new start reloads from address 0.
REQ-032 Load ramp (pixel i = i mod 256), gray_req addr 0x0081 -> gray_data=0x81 one cycle later; back-to-back addr 5,6,7 -> 0x05,0x06,0x07 in consecutive cycles.
REQ-033 gray_req addr 10 and lbp_valid addr 10 data 0xA5 same cycle -> gray_data = gray pixel 10; result[10]=0xA5.
REQ-034 Write addr 3 with 0x11 then 0x22, finish -> dump addr 3 shows 0x22; checksum 0x0033 with macro, 0x0000 without.
REQ-035 Full frame 16384 results (value = addr mod 256), dout_ready toggling 1/0 -> 16384 dout handshakes, addresses 0..16383 in order, data matches, then done=1.
REQ-036 gray_req during LOAD and lbp_valid during DUMP -> gray_data unchanged, result memory unchanged.
